// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/sequencing stage: ALUop codes and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MOD_RST,
        ST_MOD_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_mod_timer.sv
// Cycle counter supervising the multi-cycle MOD unit; flags the last permitted wait cycle.
module alu_mod_timer #(
    parameter int MOD_TIMEOUT = 1024,
    parameter int CNT_W       = $clog2(MOD_TIMEOUT) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             timeout
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != CNT_W'(MOD_TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // Asserted in the wait cycle whose increment brings the count to MOD_TIMEOUT.
    assign timeout = en && (count == CNT_W'(MOD_TIMEOUT - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue stage for the 32-bit ALU: accepts one op, drives the ALU, supervises MOD, returns the result.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MOD_TIMEOUT = 1024,
    parameter int CNT_W       = $clog2(MOD_TIMEOUT) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_reset,
    input  logic [WIDTH-1:0] alu_result
);

    state_t           state;
    logic [CNT_W-1:0] mod_count;
    logic             mod_timeout;
    logic             mod_done;

    alu_mod_timer #(
        .MOD_TIMEOUT(MOD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_MOD_RST),
        .en     (state == ST_MOD_WAIT),
        .count  (mod_count),
        .timeout(mod_timeout)
    );

    // The first wait cycle still shows the pre-restart ALU output, so it is never trusted.
    assign mod_done = (mod_count != '0) && (alu_result < alu_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_AND;
            alu_reset  <= 1'b0;
        end else begin
            alu_reset <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_op    <= req_op;
                        req_ready <= 1'b0;
                        if (req_op != OP_MOD) begin
                            state <= ST_EXEC;
                        end else if (req_b == '0) begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            alu_reset <= 1'b0;
                            state     <= ST_MOD_RST;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_MOD_RST: begin
                    state <= ST_MOD_WAIT;
                end
                ST_MOD_WAIT: begin
                    if (mod_done || mod_timeout) begin
                        rsp_result <= alu_result;
                        rsp_err    <= !mod_done;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU whose MOD unit subtracts B once per cycle.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 16;
    localparam int CW  = $clog2(TMO) + 1;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [2:0]    req_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_err;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic          alu_reset;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  mod_reg;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(
        .WIDTH      (W),
        .MOD_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_reset (alu_reset),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: MOD restarts from A while alu_reset is low, then subtracts B while the value is >= B.
    always_ff @(posedge clk) begin
        if (!alu_reset) mod_reg <= alu_a;
        else if (mod_reg >= alu_b) mod_reg <= mod_reg - alu_b;
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = mod_reg;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic err,
                         output int lat, output int pulses, output int waits);
        bit done;
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; pulses = 0; waits = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (!alu_reset) pulses++;
            else if (rsp_valid) done = 1'b1;
            else if (pulses > 0) waits++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_wait: got no rsp_valid, expected one within 100 cycles");
        end
        res = rsp_result;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish within 300 us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        err;
        int          lat, pulses, waits, stray;

        vecs[0]  = '{OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0};
        vecs[1]  = '{OP_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0};
        vecs[2]  = '{OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0};
        vecs[3]  = '{OP_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b0};
        vecs[4]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[5]  = '{OP_SLT, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0};
        vecs[6]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[7]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[8]  = '{OP_MOD, 32'd17,        32'd5,         32'd2,         1'b0};
        vecs[9]  = '{OP_MOD, 32'd3,         32'd5,         32'd3,         1'b0};
        vecs[10] = '{OP_MOD, 32'd9,         32'd0,         32'd0,         1'b1};
        vecs[11] = '{OP_MOD, 32'd100,       32'd7,         32'd2,         1'b0};

        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = OP_AND;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_err",    {31'd0, rsp_err}, 32'd0);
        check("rst_alu_a",      alu_a, 32'd0);
        check("rst_alu_b",      alu_b, 32'd0);
        check("rst_alu_op",     {29'd0, alu_op}, 32'd0);
        check("rst_alu_reset",  {31'd0, alu_reset}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_alu_reset", {31'd0, alu_reset}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, err, lat, pulses, waits);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            if (vecs[i].op != OP_MOD) begin
                check($sformatf("v%0d_latency", i), lat, 32'd2);
                check($sformatf("v%0d_pulses", i), pulses, 32'd0);
            end else begin
                check($sformatf("v%0d_pulses", i), pulses, (vecs[i].b != 0) ? 32'd1 : 32'd0);
            end
        end

        // Timeout case: 0xFFFF_FFFF modulo 1 never converges in 16 wait cycles.
        do_op(OP_MOD, 32'hFFFF_FFFF, 32'd1, res, err, lat, pulses, waits);
        check("tmo_err",    {31'd0, err}, 32'd1);
        check("tmo_result", res, 32'hFFFF_FFF0);
        check("tmo_waits",  waits, TMO);
        check("tmo_pulses", pulses, 32'd1);

        // Backpressure: response held for 5 cycles; a pending request must not be taken.
        @(negedge clk);
        req_a = 32'h7FFF_FFFF; req_b = 32'd1; req_op = OP_ADD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        stray = 0;
        while (!rsp_valid && stray < 50) begin
            @(negedge clk);
            stray++;
        end
        check("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        req_a = 32'h1234_5678; req_b = 32'd0; req_op = OP_AND; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", c),  {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp_result_%0d", c), rsp_result, 32'h8000_0000);
            check($sformatf("bp_ready_%0d", c),  {31'd0, req_ready}, 32'd0);
            check($sformatf("bp_alu_a_%0d", c),  alu_a, 32'h7FFF_FFFF);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_after_ready", {31'd0, req_ready}, 32'd1);

        // Reset during MOD_WAIT abandons the op with no response.
        @(negedge clk);
        req_a = 32'hFFFF_FFFF; req_b = 32'd1; req_op = OP_MOD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mrst_alu_reset", {31'd0, alu_reset}, 32'd0);
        check("mrst_alu_a",     alu_a, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("mrst_no_rsp", stray, 32'd0);
        do_op(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, res, err, lat, pulses, waits);
        check("mrst_next_result",  res, 32'h00F0_000F);
        check("mrst_next_err",     {31'd0, err}, 32'd0);
        check("mrst_next_latency", lat, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
